sfp_link_ctrl: RTL and testbench

Bring-up and supervision controller for the single SFP cage on GTY channel 2. The 1000BASE-X PCS/PMA runs over this lane. The block sits beside the channel-2 lane mapping: it sequences GT reset and SFP TX enable, debounces the SFP status pins, and reports link readiness to the PCS/system. It also recovers the RX datapath after a loss of signal and latches a fault after repeated lock failures.

---
 rtl/sfp_link_pkg.sv | 17 +
 rtl/sfp_debounce.sv | 46 ++++
 rtl/sfp_link_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_sfp_link_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfp_link_pkg.sv
// Shared constants and state encodings for the SFP cage bring-up controller.
package sfp_link_pkg;

  localparam int LINK_STATE_W  = 3;
  localparam int RX_RST_CYCLES = 16;

  typedef enum logic [LINK_STATE_W-1:0] {
    ST_ABSENT      = 3'd0,
    ST_TX_DIS      = 3'd1,
    ST_WAIT_LOCK   = 3'd2,
    ST_WAIT_SIGNAL = 3'd3,
    ST_LINK_UP     = 3'd4,
    ST_RX_RECOVER  = 3'd5,
    ST_FAULT       = 3'd6
  } link_state_e;

endpackage

// File: rtl/sfp_debounce.sv
// Two-flop synchronizer followed by a stability debouncer for one SFP status pin.
module sfp_debounce
  import sfp_link_pkg::*;
#(
  parameter int   STABLE_CYCLES = 1_000_000,
  parameter logic RESET_VAL     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_level
);

  localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;

  logic             r_meta;
  logic             r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  // The level only follows the synchronized pin after STABLE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta  <= RESET_VAL;
      r_sync  <= RESET_VAL;
      r_level <= RESET_VAL;
      r_cnt   <= '0;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      if (r_sync != r_level) begin
        if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          r_level <= r_sync;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/sfp_link_ctrl.sv
// SFP cage bring-up / supervision FSM for the GTY channel-2 1000BASE-X lane.
// Define SFP_LINK_CTRL_STATS_EN to add the saturating link_drops counter output.
module sfp_link_ctrl
  import sfp_link_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 1_000_000,
  parameter int TX_DIS_CYCLES       = 10_000,
  parameter int LOCK_TIMEOUT_CYCLES = 2_500_000,
  parameter int MAX_RETRIES         = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sfp_mod_abs,
  input  logic                    sfp_rx_los,
  input  logic                    sfp_tx_fault,
  input  logic                    gt_pll_lock,
  input  logic                    gt_tx_reset_done,
  input  logic                    gt_rx_reset_done,
  input  logic                    pcs_link_up,
  output logic                    sfp_tx_disable,
  output logic                    gt_reset_all,
  output logic                    gt_rx_reset_datapath,
  output logic                    link_ready,
  output logic [LINK_STATE_W-1:0] link_state,
  output logic [3:0]              retry_count,
  output logic                    fault
`ifdef SFP_LINK_CTRL_STATS_EN
  ,
  output logic [15:0]             link_drops
`endif
);

  localparam int MAX_A  = (DEBOUNCE_CYCLES > TX_DIS_CYCLES) ? DEBOUNCE_CYCLES : TX_DIS_CYCLES;
  localparam int MAX_C  = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W  = $clog2(MAX_C) + 1;

  localparam logic [LINK_STATE_W-1:0] S_ABSENT      = ST_ABSENT;
  localparam logic [LINK_STATE_W-1:0] S_TX_DIS      = ST_TX_DIS;
  localparam logic [LINK_STATE_W-1:0] S_WAIT_LOCK   = ST_WAIT_LOCK;
  localparam logic [LINK_STATE_W-1:0] S_WAIT_SIGNAL = ST_WAIT_SIGNAL;
  localparam logic [LINK_STATE_W-1:0] S_LINK_UP     = ST_LINK_UP;
  localparam logic [LINK_STATE_W-1:0] S_RX_RECOVER  = ST_RX_RECOVER;
  localparam logic [LINK_STATE_W-1:0] S_FAULT       = ST_FAULT;

  logic                    w_mod_abs_db;
  logic                    w_rx_los_db;
  logic                    r_tx_fault_meta;
  logic                    r_tx_fault_sync;
  logic [LINK_STATE_W-1:0] r_state;
  logic [LINK_STATE_W-1:0] w_next;
  logic [3:0]              r_retry;
  logic [3:0]              w_retry_next;
  logic [3:0]              w_retry_inc;
  logic                    w_retry_evt;
  logic                    w_timer_done;
  logic                    w_gt_ok;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_load;

  sfp_debounce #(
    .STABLE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_VAL     (1'b1)
  ) u_db_mod_abs (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pin   (sfp_mod_abs),
    .o_level (w_mod_abs_db)
  );

  sfp_debounce #(
    .STABLE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_VAL     (1'b1)
  ) u_db_rx_los (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pin   (sfp_rx_los),
    .o_level (w_rx_los_db)
  );

  // Laser fault is acted on immediately, so it is only synchronized.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_fault_meta <= 1'b0;
      r_tx_fault_sync <= 1'b0;
    end else begin
      r_tx_fault_meta <= sfp_tx_fault;
      r_tx_fault_sync <= r_tx_fault_meta;
    end
  end

  assign w_gt_ok      = gt_pll_lock & gt_tx_reset_done & gt_rx_reset_done;
  assign w_timer_done = (r_cnt == '0);
  assign w_retry_inc  = r_retry + 4'd1;

  always_comb begin
    w_next       = r_state;
    w_retry_next = r_retry;
    w_retry_evt  = 1'b0;
    case (r_state)
      S_ABSENT:      if (!w_mod_abs_db) w_next = S_TX_DIS;
      S_TX_DIS:      if (w_timer_done) w_next = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (w_gt_ok)           w_next      = S_WAIT_SIGNAL;
        else if (w_timer_done) w_retry_evt = 1'b1;
      end
      S_WAIT_SIGNAL: begin
        if (r_tx_fault_sync)                   w_retry_evt = 1'b1;
        else if (!w_rx_los_db && pcs_link_up)  w_next      = S_LINK_UP;
      end
      S_LINK_UP: begin
        if (r_tx_fault_sync)                   w_retry_evt = 1'b1;
        else if (w_rx_los_db || !pcs_link_up)  w_next      = S_RX_RECOVER;
      end
      S_RX_RECOVER: begin
        if (r_tx_fault_sync)   w_retry_evt = 1'b1;
        else if (w_timer_done) w_next      = S_WAIT_SIGNAL;
      end
      S_FAULT:       w_next = S_FAULT;
      default:       w_next = S_ABSENT;
    endcase
    if (w_retry_evt) begin
      w_retry_next = w_retry_inc;
      w_next       = (w_retry_inc == 4'(MAX_RETRIES)) ? S_FAULT : S_TX_DIS;
    end
    // Module removal overrides everything, including a retry in the same cycle.
    if (w_mod_abs_db && (r_state != S_ABSENT)) begin
      w_next       = S_ABSENT;
      w_retry_next = 4'd0;
    end
  end

  always_comb begin
    w_cnt_load = '0;
    case (w_next)
      S_TX_DIS:     w_cnt_load = CNT_W'(TX_DIS_CYCLES - 1);
      S_WAIT_LOCK:  w_cnt_load = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
      S_RX_RECOVER: w_cnt_load = CNT_W'(RX_RST_CYCLES - 1);
      default:      w_cnt_load = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ABSENT;
      r_retry <= 4'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_retry <= w_retry_next;
      if (w_next != r_state)  r_cnt <= w_cnt_load;
      else if (!w_timer_done) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Outputs are a registered decode of the state, one cycle behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sfp_tx_disable       <= 1'b1;
      gt_reset_all         <= 1'b1;
      gt_rx_reset_datapath <= 1'b0;
      link_ready           <= 1'b0;
      link_state           <= S_ABSENT;
      retry_count          <= 4'd0;
      fault                <= 1'b0;
    end else begin
      sfp_tx_disable       <= (r_state == S_ABSENT) || (r_state == S_TX_DIS) || (r_state == S_FAULT);
      gt_reset_all         <= (r_state == S_ABSENT) || (r_state == S_TX_DIS) || (r_state == S_FAULT);
      gt_rx_reset_datapath <= (r_state == S_RX_RECOVER);
      link_ready           <= (r_state == S_LINK_UP);
      link_state           <= r_state;
      retry_count          <= r_retry;
      fault                <= (r_state == S_FAULT);
    end
  end

`ifdef SFP_LINK_CTRL_STATS_EN
  logic [15:0] r_link_drops;

  // Survives module removal; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_link_drops <= 16'd0;
    end else if ((r_state == S_LINK_UP) && (w_next == S_RX_RECOVER) &&
                 (r_link_drops != 16'hFFFF)) begin
      r_link_drops <= r_link_drops + 16'd1;
    end
  end

  assign link_drops = r_link_drops;
`endif

endmodule

// File: tb/tb_sfp_link_ctrl.sv
// Directed bench for sfp_link_ctrl with an elapsed-time behavioural model checked every cycle.
module tb_sfp_link_ctrl;

  localparam int DBN  = 8;
  localparam int TXD  = 20;
  localparam int LCK  = 100;
  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sfp_mod_abs = 1'b0;
  logic       sfp_rx_los = 1'b0;
  logic       sfp_tx_fault = 1'b0;
  logic       gt_pll_lock = 1'b1;
  logic       gt_tx_reset_done = 1'b1;
  logic       gt_rx_reset_done = 1'b1;
  logic       pcs_link_up = 1'b0;
  logic       sfp_tx_disable;
  logic       gt_reset_all;
  logic       gt_rx_reset_datapath;
  logic       link_ready;
  logic [2:0] link_state;
  logic [3:0] retry_count;
  logic       fault;
`ifdef SFP_LINK_CTRL_STATS_EN
  logic [15:0] link_drops;
`endif

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  sfp_link_ctrl #(
    .DEBOUNCE_CYCLES     (DBN),
    .TX_DIS_CYCLES       (TXD),
    .LOCK_TIMEOUT_CYCLES (LCK),
    .MAX_RETRIES         (MAXR)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .sfp_mod_abs          (sfp_mod_abs),
    .sfp_rx_los           (sfp_rx_los),
    .sfp_tx_fault         (sfp_tx_fault),
    .gt_pll_lock          (gt_pll_lock),
    .gt_tx_reset_done     (gt_tx_reset_done),
    .gt_rx_reset_done     (gt_rx_reset_done),
    .pcs_link_up          (pcs_link_up),
    .sfp_tx_disable       (sfp_tx_disable),
    .gt_reset_all         (gt_reset_all),
    .gt_rx_reset_datapath (gt_rx_reset_datapath),
    .link_ready           (link_ready),
    .link_state           (link_state),
    .retry_count          (retry_count),
    .fault                (fault)
`ifdef SFP_LINK_CTRL_STATS_EN
    ,
    .link_drops           (link_drops)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: state as an int, time-in-state counted upward, debouncers as run-length counters.
  int ms = 0, mt = 0, mretry = 0;
  int a1 = 1, a2 = 1, adb = 1, arun = 0;
  int l1 = 1, l2 = 1, ldb = 1, lrun = 0;
  int tf1 = 0, tf2 = 0;
  logic       e_txdis = 1'b1, e_gtrst = 1'b1, e_rxrst = 1'b0, e_ready = 1'b0, e_fault = 1'b0;
  logic [2:0] e_state = 3'd0;
  logic [3:0] e_retry = 4'd0;

  always @(posedge clk) begin
    int ns, nr;
    bit rty;
    if (!rst_n) begin
      ms = 0; mt = 0; mretry = 0;
      a1 = 1; a2 = 1; adb = 1; arun = 0;
      l1 = 1; l2 = 1; ldb = 1; lrun = 0;
      tf1 = 0; tf2 = 0;
      e_txdis = 1; e_gtrst = 1; e_rxrst = 0; e_ready = 0; e_fault = 0;
      e_state = 0; e_retry = 0;
    end else begin
      e_txdis = (ms == 0 || ms == 1 || ms == 6);
      e_gtrst = e_txdis;
      e_rxrst = (ms == 5);
      e_ready = (ms == 4);
      e_fault = (ms == 6);
      e_state = 3'(ms);
      e_retry = 4'(mretry);
      ns = ms; rty = 0;
      case (ms)
        0: if (adb == 0) ns = 1;
        1: if (mt == TXD - 1) ns = 2;
        2: if (gt_pll_lock && gt_tx_reset_done && gt_rx_reset_done) ns = 3;
           else if (mt == LCK - 1) rty = 1;
        3: if (tf2 == 1) rty = 1; else if (ldb == 0 && pcs_link_up) ns = 4;
        4: if (tf2 == 1) rty = 1; else if (ldb == 1 || !pcs_link_up) ns = 5;
        5: if (tf2 == 1) rty = 1; else if (mt == 15) ns = 3;
        default: ;
      endcase
      nr = mretry;
      if (rty) begin
        nr = mretry + 1;
        ns = (nr == MAXR) ? 6 : 1;
      end
      if (adb == 1 && ms != 0) begin
        ns = 0;
        nr = 0;
      end
      mt = (ns != ms) ? 0 : mt + 1;
      ms = ns;
      mretry = nr;
      if (a2 != adb) begin arun++; if (arun == DBN) begin adb = a2; arun = 0; end end
      else arun = 0;
      if (l2 != ldb) begin lrun++; if (lrun == DBN) begin ldb = l2; lrun = 0; end end
      else lrun = 0;
      a2 = a1; a1 = int'(sfp_mod_abs);
      l2 = l1; l1 = int'(sfp_rx_los);
      tf2 = tf1; tf1 = int'(sfp_tx_fault);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("tx_disable", 32'(sfp_tx_disable), 32'(e_txdis));
      chk("gt_reset_all", 32'(gt_reset_all), 32'(e_gtrst));
      chk("rx_reset_dp", 32'(gt_rx_reset_datapath), 32'(e_rxrst));
      chk("link_ready", 32'(link_ready), 32'(e_ready));
      chk("link_state", 32'(link_state), 32'(e_state));
      chk("retry_count", 32'(retry_count), 32'(e_retry));
      chk("fault", 32'(fault), 32'(e_fault));
    end
  end

  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    int k;
    k = 0;
    while (link_state !== s && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(link_state), 32'(s));
  endtask

  task automatic wait_retry(input logic [3:0] r, input int budget, input string nm);
    int k;
    k = 0;
    while (retry_count !== r && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(retry_count), 32'(r));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst tx_disable", 32'(sfp_tx_disable), 32'd1);
    chk("rst gt_reset_all", 32'(gt_reset_all), 32'd1);
    chk("rst link_state", 32'(link_state), 32'd0);
    chk("rst retry_count", 32'(retry_count), 32'd0);
    chk("rst link_ready", 32'(link_ready), 32'd0);
    rst_n = 1'b1;

    // Nominal bring-up.
    wait_state(3'd1, 40, "enter TX_DIS");
    cnt = 0;
    while (sfp_tx_disable === 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("tx_disable hold", 32'(cnt), 32'd20);
    wait_state(3'd3, 10, "enter WAIT_SIGNAL");
    repeat (10) @(negedge clk);
    chk("no link yet", 32'(link_state), 32'd3);
    pcs_link_up = 1'b1;
    wait_state(3'd4, 10, "enter LINK_UP");
    chk("link_ready up", 32'(link_ready), 32'd1);

    // LOS glitch shorter than the debounce window, then a real loss.
    sfp_rx_los = 1'b1;
    repeat (5) @(negedge clk);
    sfp_rx_los = 1'b0;
    repeat (20) @(negedge clk);
    chk("los glitch ignored", 32'(link_state), 32'd4);
    sfp_rx_los = 1'b1;
    repeat (12) @(negedge clk);
    sfp_rx_los = 1'b0;
    wait_state(3'd5, 20, "enter RX_RECOVER");
    cnt = 0;
    while (gt_rx_reset_datapath === 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("rx reset width", 32'(cnt), 32'd16);
    chk("after recover", 32'(link_state), 32'd3);
    wait_state(3'd4, 40, "relink after LOS");

    // Two link drops from the PCS side.
    for (int i = 0; i < 2; i++) begin
      pcs_link_up = 1'b0;
      repeat (2) @(negedge clk);
      pcs_link_up = 1'b1;
      wait_state(3'd5, 10, "pcs drop recover");
      wait_state(3'd4, 40, "pcs relink");
    end
`ifdef SFP_LINK_CTRL_STATS_EN
    chk("link_drops", 32'(link_drops), 32'd3);
`endif

    // Laser fault while up is a retry.
    sfp_tx_fault = 1'b1;
    repeat (3) @(negedge clk);
    sfp_tx_fault = 1'b0;
    wait_state(3'd1, 10, "tx_fault retry");
    chk("retry after tx_fault", 32'(retry_count), 32'd1);
    wait_state(3'd4, 60, "relink after tx_fault");

    // Removal clears retries; then three lock timeouts latch FAULT.
    gt_pll_lock = 1'b0;
    sfp_mod_abs = 1'b1;
    wait_state(3'd0, 30, "removal ABSENT");
    chk("removal clears retry", 32'(retry_count), 32'd0);
    repeat (5) @(negedge clk);
    sfp_mod_abs = 1'b0;
    wait_state(3'd2, 60, "enter WAIT_LOCK");
    wait_state(3'd6, 600, "enter FAULT");
    chk("fault flag", 32'(fault), 32'd1);
    chk("fault tx_disable", 32'(sfp_tx_disable), 32'd1);
    chk("fault retry", 32'(retry_count), 32'd3);
    repeat (30) @(negedge clk);
    chk("fault held", 32'(link_state), 32'd6);

    // Recovery from FAULT by removal and reinsertion.
    sfp_mod_abs = 1'b1;
    wait_state(3'd0, 30, "fault removal");
    chk("fault removal retry", 32'(retry_count), 32'd0);
    chk("fault removal flag", 32'(fault), 32'd0);
    repeat (5) @(negedge clk);
    sfp_mod_abs = 1'b0;
    wait_state(3'd1, 30, "reinsert TX_DIS");

    // Debounced removal lands on the same cycle as a lock timeout.
    wait_retry(4'd1, 200, "first timeout");
    wait_state(3'd2, 40, "second WAIT_LOCK");
    repeat (88) @(negedge clk);
    sfp_mod_abs = 1'b1;
    wait_state(3'd0, 30, "simultaneous ABSENT");
    chk("simultaneous retry", 32'(retry_count), 32'd0);
    repeat (5) @(negedge clk);
    sfp_mod_abs = 1'b0;
    gt_pll_lock = 1'b1;

    // Asynchronous reset mid-link.
    wait_state(3'd4, 80, "relink before reset");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async tx_disable", 32'(sfp_tx_disable), 32'd1);
    chk("async gt_reset_all", 32'(gt_reset_all), 32'd1);
    chk("async link_ready", 32'(link_ready), 32'd0);
    chk("async link_state", 32'(link_state), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_state(3'd4, 80, "relink after reset");
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
